// File: rtl/ghash_core_step_pkg.sv
// ---------------------------------------------------------------------------
// ghash_core_step_pkg
// Shared constants for the GHASH stage and its GF(2^128) multiplier.
//   NB_DATA : GHASH block width. The multiplier is hard-wired to 128 bits
//             because the reduction polynomial only exists for GF(2^128).
//   GCM_R   : GCM reduction constant (0xE1 followed by 120 zero bits). It is
//             the reflected form of x^128 + x^7 + x^2 + x + 1, because GCM
//             stores the x^0 coefficient in the MSB.
// ---------------------------------------------------------------------------
package ghash_core_step_pkg;

   localparam int NB_DATA = 128;

   localparam logic [127:0] GCM_R = 128'hE1 << 120;

endpackage : ghash_core_step_pkg

// File: rtl/ghash_core_step_gf128_mult_gcm.sv
// ---------------------------------------------------------------------------
// gf128_mult_gcm
// Purely combinational GF(2^128) multiplier using GCM bit ordering.
// The MSB holds the x^0 coefficient and the LSB holds the x^127 coefficient.
// Ports:
//   a [127:0] : multiplicand
//   b [127:0] : multiplier
//   y [127:0] : product a*b in GF(2^128)
// ---------------------------------------------------------------------------
module gf128_mult_gcm
   import ghash_core_step_pkg::*;
(
   input  logic [127:0] a,
   input  logic [127:0] b,
   output logic [127:0] y
);

   logic [127:0] w_accum;
   logic [127:0] w_shifted;

   // Bit-serial shift-and-add algorithm, fully unrolled by synthesis into an
   // XOR network. w_shifted walks through b*x^i. A right shift is a
   // multiplication by x in the reflected bit order. When a set bit falls
   // off the LSB (the x^127 coefficient), the product is folded back in with
   // GCM_R. w_accum collects the partial products selected by the bits of a,
   // taken from the MSB (x^0) down to the LSB.
   always_comb begin
      w_accum   = '0;
      w_shifted = b;
      for (int i = 0; i < 128; i++) begin
         if (a[127-i]) begin
            w_accum = w_accum ^ w_shifted;
         end
         if (w_shifted[0]) begin
            w_shifted = (w_shifted >> 1) ^ GCM_R;
         end else begin
            w_shifted = w_shifted >> 1;
         end
      end
      y = w_accum;
   end

endmodule : gf128_mult_gcm

// File: rtl/ghash_core_step.sv
// ---------------------------------------------------------------------------
// ghash_core_step
// One GHASH iteration for AES-GCM:
//   Y_i = (X_i xor Y_{i-1}) * H   in GF(2^128)
// The result is registered with one cycle of latency and a throughput of one
// block per cycle. Stages can be chained through o_data_y.
// Ports:
//   i_clock       : clock, rising edge
//   i_reset       : synchronous active-high reset, clears o_data_y
//   o_data_y      : registered GHASH value Y_i
//   i_data_x      : current block X_i (AAD, ciphertext or length block)
//   i_data_x_prev : previous GHASH value Y_{i-1} (zero for the first block)
//   i_h_key       : hash subkey H
//   i_valid       : loads the new product on this edge when high
// ---------------------------------------------------------------------------
module ghash_core_step
   import ghash_core_step_pkg::*;
#(
   parameter int NB_DATA = ghash_core_step_pkg::NB_DATA
)
(
   input  logic               i_clock,
   input  logic               i_reset,
   output logic [NB_DATA-1:0] o_data_y,
   input  logic [NB_DATA-1:0] i_data_x,
   input  logic [NB_DATA-1:0] i_data_x_prev,
   input  logic [NB_DATA-1:0] i_h_key,
   input  logic               i_valid
);

   logic [NB_DATA-1:0] w_mixed;
   logic [NB_DATA-1:0] w_product;
   logic [NB_DATA-1:0] r_dataY;

   // The new block is folded into the running hash before the multiply.
   assign w_mixed = i_data_x ^ i_data_x_prev;

   gf128_mult_gcm u_mult (
      .a (w_mixed),
      .b (i_h_key),
      .y (w_product)
   );

   // This is the only state in the stage. Reset wins over valid. When valid
   // is low, the register holds the last hash value.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_dataY <= '0;
      end else if (i_valid) begin
         r_dataY <= w_product;
      end
   end

   assign o_data_y = r_dataY;

endmodule : ghash_core_step

// File: tb/tb_ghash_core_step.sv
// ---------------------------------------------------------------------------
// tb_ghash_core_step
// Testbench for ghash_core_step. It uses three instances:
//   dut0    : main stage
//   dut1    : chained stage, fed by dut0 through i_data_x_prev
//   dutSwap : takes the operands of dut0 in swapped positions
// ---------------------------------------------------------------------------
module tb_ghash_core_step;

   localparam logic [127:0] H_TC2   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] X_TC2   = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] Y_TC2   = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [127:0] TAG_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [127:0] ONE     = 128'h80000000000000000000000000000000;
   localparam logic [127:0] LEN_TC2 = 128'h80;

   typedef struct {
      string        name;
      logic [127:0] x;
      logic [127:0] prev;
      logic [127:0] h;
      logic [127:0] expY;
   } vec_t;

   logic         clock;
   logic         reset;
   logic         valid;
   logic [127:0] x0, prev0, h0, y0;
   logic [127:0] x1, h1, y1;
   logic [127:0] xs, prevs, hs, ys;

   int total;
   int bad;

   vec_t vecs[6];

   ghash_core_step dut0 (
      .i_clock       (clock),
      .i_reset       (reset),
      .o_data_y      (y0),
      .i_data_x      (x0),
      .i_data_x_prev (prev0),
      .i_h_key       (h0),
      .i_valid       (valid)
   );

   ghash_core_step dut1 (
      .i_clock       (clock),
      .i_reset       (reset),
      .o_data_y      (y1),
      .i_data_x      (x1),
      .i_data_x_prev (y0),
      .i_h_key       (h1),
      .i_valid       (valid)
   );

   ghash_core_step dutSwap (
      .i_clock       (clock),
      .i_reset       (reset),
      .o_data_y      (ys),
      .i_data_x      (xs),
      .i_data_x_prev (prevs),
      .i_h_key       (hs),
      .i_valid       (valid)
   );

   // Free-running clock with a 10-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: the GCM shift-and-add multiply, one bit per step.
   function automatic logic [127:0] refGfmul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] z;
      logic [127:0] v;
      z = '0;
      v = b;
      for (int i = 0; i < 128; i++) begin
         if (a[127-i]) z = z ^ v;
         v = v[0] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
      end
      return z;
   endfunction

   // Compares one value against its expectation and updates the counters.
   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drives dut0 for one cycle. The outputs are sampled 1 unit after the edge.
   task automatic applyStimulus(input logic [127:0] x, input logic [127:0] prev,
                                input logic [127:0] h, input logic v);
      x0    = x;
      prev0 = prev;
      h0    = h;
      valid = v;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [127:0] rx, rp, rh, expect0;

      total = 0;
      bad   = 0;

      vecs[0] = '{"tc2_block",   X_TC2,               128'h0,               H_TC2, Y_TC2};
      vecs[1] = '{"one_times_h", ONE,                 128'h0,               H_TC2, H_TC2};
      vecs[2] = '{"h_zero",      X_TC2,               128'h0,               128'h0, 128'h0};
      vecs[3] = '{"x_eq_prev",   128'h0123456789abcdef_fedcba9876543210,
                                 128'h0123456789abcdef_fedcba9876543210,    H_TC2, 128'h0};
      vecs[4] = '{"prev_only",   128'h0,              X_TC2,                H_TC2, Y_TC2};
      vecs[5] = '{"one_via_prev",128'h0,              ONE,                  X_TC2, X_TC2};

      // Hold reset for two edges and check that every instance comes up at zero.
      reset = 1'b1;
      valid = 1'b0;
      x0 = '0; prev0 = '0; h0 = '0;
      x1 = '0; h1 = '0;
      xs = '0; prevs = '0; hs = '0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("reset_y0", y0, 128'h0);
      checkOutput("reset_y1", y1, 128'h0);
      checkOutput("reset_ys", ys, 128'h0);
      reset = 1'b0;

      // Table-driven directed vectors.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].x, vecs[i].prev, vecs[i].h, 1'b1);
         checkOutput(vecs[i].name, y0, vecs[i].expY);
      end

      // Chain: data block, then length block, starting from a fresh reset.
      reset = 1'b1;
      applyStimulus(X_TC2, 128'h0, H_TC2, 1'b1);
      reset = 1'b0;
      x1 = LEN_TC2;
      h1 = H_TC2;
      applyStimulus(X_TC2, 128'h0, H_TC2, 1'b1);
      checkOutput("chain_stage0", y0, Y_TC2);
      applyStimulus(X_TC2, 128'h0, H_TC2, 1'b1);
      checkOutput("chain_tag", y1, TAG_TC2);

      // Reset during a valid cycle clears the output. The next valid edge reloads it.
      reset = 1'b1;
      applyStimulus(X_TC2, 128'h0, H_TC2, 1'b1);
      checkOutput("mid_reset", y0, 128'h0);
      reset = 1'b0;
      applyStimulus(X_TC2, 128'h0, H_TC2, 1'b1);
      checkOutput("after_reset", y0, Y_TC2);

      // With valid low, the output holds while the inputs change.
      for (int i = 0; i < 5; i++) begin
         applyStimulus({$urandom, $urandom, $urandom, $urandom}, 128'h0, H_TC2, 1'b0);
         checkOutput("hold", y0, Y_TC2);
      end

      // Random vectors against the model. dutSwap checks commutativity.
      for (int i = 0; i < 1000; i++) begin
         rx = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         rh = {$urandom, $urandom, $urandom, $urandom};
         xs    = rh;
         prevs = 128'h0;
         hs    = rx ^ rp;
         expect0 = refGfmul(rx ^ rp, rh);
         applyStimulus(rx, rp, rh, 1'b1);
         checkOutput("random", y0, expect0);
         checkOutput("commute", ys, expect0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ghash_core_step
